// File: rtl/ring_decoder_if.sv
// Observation bus of the ring-counter decoder: the sampled code in, the decoded
// position, the lock/fault status and the event counters out.
interface ring_decoder_if;
  logic [3:0] count_in;
  logic [1:0] index;
  logic       valid;
  logic       locked;
  logic       seq_err;
  logic       stuck;
  logic [7:0] err_count;
  logic [7:0] rev_count;

  modport master (
    output count_in,
    input  index, valid, locked, seq_err, stuck, err_count, rev_count
  );

  modport slave (
    input  count_in,
    output index, valid, locked, seq_err, stuck, err_count, rev_count
  );
endinterface

// File: rtl/ring_decoder.sv
// Watches a 4-bit one-hot ring counter: decodes its position, tracks lock on
// correct rotation, flags sequence errors while locked and detects a stuck ring.
module ring_decoder #(
  parameter int unsigned LOCK_N  = 4,
  parameter int unsigned STUCK_N = 3
) (
  input  logic           clk,
  input  logic           reset,
  ring_decoder_if.slave  bus
);

  localparam int unsigned SW = ($clog2(LOCK_N + 1) < 1) ? 1 : $clog2(LOCK_N + 1);
  localparam int unsigned ZW = ($clog2(STUCK_N + 1) < 1) ? 1 : $clog2(STUCK_N + 1);
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_prev;
  logic [SW-1:0]   r_streak;
  logic [ZW-1:0]   r_zero_run;
  logic [1:0]      r_index;
  logic            r_valid;
  logic            r_locked;
  logic            r_seq_err;
  logic            r_stuck;
  logic [CW-1:0]   r_err_count;
  logic [CW-1:0]   r_rev_count;

  state_t          w_state_nxt;
  logic [SW-1:0]   w_streak_nxt;
  logic [ZW-1:0]   w_zero_run_nxt;
  logic [1:0]      w_index_nxt;
  logic            w_valid_nxt;
  logic            w_locked_nxt;
  logic            w_seq_err_nxt;
  logic            w_stuck_nxt;
  logic [CW-1:0]   w_err_count_nxt;
  logic [CW-1:0]   w_rev_count_nxt;

  logic [3:0]      w_sample;
  logic            w_onehot;
  logic [1:0]      w_enc;
  logic            w_zero;
  logic            w_adv;
  logic            w_fault_hit;
  logic [SW-1:0]   w_streak_inc;

  // Sample decode: one-hot position and whether it is the expected rotation.
  always_comb begin
    w_sample = bus.count_in;
    w_onehot = 1'b1;
    w_enc    = 2'd0;
    case (w_sample)
      4'b0001: w_enc = 2'd0;
      4'b0010: w_enc = 2'd1;
      4'b0100: w_enc = 2'd2;
      4'b1000: w_enc = 2'd3;
      default: w_onehot = 1'b0;
    endcase
    w_zero       = (w_sample == 4'b0000);
    w_adv        = $onehot(r_prev) && (w_sample == {r_prev[2:0], r_prev[3]});
    w_streak_inc = r_streak + SW'(1);
  end

  // Zero-run tracking saturates at STUCK_N so a long dead ring cannot wrap it.
  always_comb begin
    w_zero_run_nxt = '0;
    if (w_zero) begin
      if (r_zero_run == ZW'(STUCK_N)) begin
        w_zero_run_nxt = r_zero_run;
      end else begin
        w_zero_run_nxt = r_zero_run + ZW'(1);
      end
    end
    w_fault_hit = w_zero && (w_zero_run_nxt == ZW'(STUCK_N));
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_streak_nxt    = r_streak;
    w_seq_err_nxt   = 1'b0;
    w_err_count_nxt = r_err_count;
    w_rev_count_nxt = r_rev_count;
    w_index_nxt     = w_onehot ? w_enc : r_index;
    w_valid_nxt     = w_onehot;

    case (r_state)
      ST_SEARCH: begin
        if (w_fault_hit) begin
          w_state_nxt  = ST_FAULT;
          w_streak_nxt = '0;
        end else if (w_adv) begin
          w_streak_nxt = w_streak_inc;
          if (w_streak_inc == SW'(LOCK_N)) begin
            w_state_nxt = ST_LOCKED;
          end
        end else begin
          w_streak_nxt = '0;
        end
      end

      ST_LOCKED: begin
        if (!w_adv) begin
          w_seq_err_nxt = 1'b1;
          w_streak_nxt  = '0;
          w_state_nxt   = w_fault_hit ? ST_FAULT : ST_SEARCH;
          if (r_err_count != {CW{1'b1}}) begin
            w_err_count_nxt = r_err_count + CW'(1);
          end
        end else if (w_sample == 4'b0001) begin
          w_rev_count_nxt = r_rev_count + CW'(1);
        end
      end

      ST_FAULT: begin
        w_streak_nxt = '0;
        if (w_onehot) begin
          w_state_nxt = ST_SEARCH;
        end
      end

      default: begin
        w_state_nxt  = ST_SEARCH;
        w_streak_nxt = '0;
      end
    endcase

    w_locked_nxt = (w_state_nxt == ST_LOCKED);
    w_stuck_nxt  = (w_state_nxt == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_SEARCH;
      r_prev      <= 4'b0000;
      r_streak    <= '0;
      r_zero_run  <= '0;
      r_index     <= 2'd0;
      r_valid     <= 1'b0;
      r_locked    <= 1'b0;
      r_seq_err   <= 1'b0;
      r_stuck     <= 1'b0;
      r_err_count <= '0;
      r_rev_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev      <= w_sample;
      r_streak    <= w_streak_nxt;
      r_zero_run  <= w_zero_run_nxt;
      r_index     <= w_index_nxt;
      r_valid     <= w_valid_nxt;
      r_locked    <= w_locked_nxt;
      r_seq_err   <= w_seq_err_nxt;
      r_stuck     <= w_stuck_nxt;
      r_err_count <= w_err_count_nxt;
      r_rev_count <= w_rev_count_nxt;
    end
  end

  assign bus.index     = r_index;
  assign bus.valid     = r_valid;
  assign bus.locked    = r_locked;
  assign bus.seq_err   = r_seq_err;
  assign bus.stuck     = r_stuck;
  assign bus.err_count = r_err_count;
  assign bus.rev_count = r_rev_count;

endmodule

// File: tb/tb_ring_decoder.sv
// Bench for ring_decoder: directed vector table, hand sequences for the
// saturation/reset corners, and random samples against a behavioural model.
module tb_ring_decoder;

  localparam int LOCK_N  = 4;
  localparam int STUCK_N = 3;

  logic clk;
  logic reset;
  ring_decoder_if bus ();

  ring_decoder #(.LOCK_N(LOCK_N), .STUCK_N(STUCK_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Behavioural model: position-based, counts in plain integers.
  int m_prev_pos;
  int m_run;
  int m_zeros;
  bit m_locked;
  bit m_stuck;
  bit m_seq;
  bit m_valid;
  int m_index;
  int m_err;
  int m_rev;

  function automatic int pos_of(input logic [3:0] s);
    for (int i = 0; i < 4; i++) begin
      if (s == (4'b0001 << i)) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] s, input logic r);
    int  p;
    bit  adv;
    if (r) begin
      m_prev_pos = -1; m_run = 0; m_zeros = 0;
      m_locked = 0; m_stuck = 0; m_seq = 0; m_valid = 0;
      m_index = 0; m_err = 0; m_rev = 0;
      return;
    end
    p   = pos_of(s);
    adv = (m_prev_pos >= 0) && (p == (m_prev_pos + 1) % 4);
    m_zeros = (s == 4'b0000) ? ((m_zeros + 1 > STUCK_N) ? STUCK_N : m_zeros + 1) : 0;
    m_seq = 0;
    if (m_stuck) begin
      if (p >= 0) begin
        m_stuck = 0;
        m_run   = 0;
      end
    end else if (m_locked) begin
      if (!adv) begin
        m_seq    = 1;
        m_err    = (m_err < 255) ? m_err + 1 : 255;
        m_locked = 0;
        m_run    = 0;
      end else if (p == 0) begin
        m_rev = (m_rev + 1) % 256;
      end
    end else begin
      m_run = adv ? m_run + 1 : 0;
      if (m_run == LOCK_N) m_locked = 1;
    end
    if (m_zeros == STUCK_N) begin
      m_stuck  = 1;
      m_locked = 0;
      m_run    = 0;
    end
    if (p >= 0) begin
      m_index = p;
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    m_prev_pos = p;
  endtask

  function automatic logic [21:0] dut_word();
    return {bus.index, bus.valid, bus.locked, bus.seq_err, bus.stuck,
            bus.err_count, bus.rev_count};
  endfunction

  function automatic logic [21:0] model_word();
    return {2'(m_index), m_valid, m_locked, m_seq, m_stuck, 8'(m_err), 8'(m_rev)};
  endfunction

  task automatic check_word(input string name, input int step,
                            input logic [21:0] got, input logic [21:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s step=%0d got idx=%0d v=%0b lk=%0b se=%0b st=%0b err=%0d rev=%0d exp idx=%0d v=%0b lk=%0b se=%0b st=%0b err=%0d rev=%0d",
               name, step, got[21:20], got[19], got[18], got[17], got[16], got[15:8], got[7:0],
               exp[21:20], exp[19], exp[18], exp[17], exp[16], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  int step_no;

  // One clock: drive away from the edge, advance the model, sample after the edge.
  task automatic apply(input logic [3:0] s, input logic r);
    @(negedge clk);
    bus.count_in = s;
    reset        = r;
    @(posedge clk);
    model_step(s, r);
    #1;
    step_no++;
    check_word("model", step_no, dut_word(), model_word());
  endtask

  task automatic lock_up();
    apply(4'b0001, 1'b0);
    apply(4'b0010, 1'b0);
    apply(4'b0100, 1'b0);
    apply(4'b1000, 1'b0);
    apply(4'b0001, 1'b0);
  endtask

  typedef struct {
    logic [3:0] s;
    logic       rst;
    logic [1:0] idx;
    logic       valid;
    logic       locked;
    logic       seq_err;
    logic       stuck;
    logic [7:0] err;
    logic [7:0] rev;
  } vec_t;

  vec_t tbl [28];

  initial begin
    logic [3:0] s;
    int         pick;
    n_vec = 0; n_err = 0; step_no = 0;
    reset = 1'b1;
    bus.count_in = 4'b0000;

    // lock-up, revolution, error recovery, multi-hot and stuck-ring scenarios
    tbl[0]  = '{4'b0000, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[1]  = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[2]  = '{4'b0010, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[3]  = '{4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[4]  = '{4'b1000, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[5]  = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[6]  = '{4'b0010, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[7]  = '{4'b0100, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[8]  = '{4'b1000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[9]  = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd1};
    tbl[10] = '{4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 8'd1};
    tbl[11] = '{4'b1000, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1};
    tbl[12] = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1};
    tbl[13] = '{4'b0010, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1};
    tbl[14] = '{4'b0100, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1};
    tbl[15] = '{4'b1000, 1'b0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1};
    tbl[16] = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd2};
    tbl[17] = '{4'b0010, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd2};
    tbl[18] = '{4'b0110, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd2};
    tbl[19] = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2};
    tbl[20] = '{4'b0010, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2};
    tbl[21] = '{4'b0100, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2};
    tbl[22] = '{4'b1000, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2};
    tbl[23] = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 8'd2};
    tbl[24] = '{4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 8'd2};
    tbl[25] = '{4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'd2};
    tbl[26] = '{4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 8'd2};
    tbl[27] = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 8'd2};

    for (int i = 0; i < 28; i++) begin
      apply(tbl[i].s, tbl[i].rst);
      check_word("table", i, dut_word(),
                 {tbl[i].idx, tbl[i].valid, tbl[i].locked, tbl[i].seq_err,
                  tbl[i].stuck, tbl[i].err, tbl[i].rev});
    end

    // Reset while locked with non-zero counters clears everything on that edge.
    apply(4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) begin
      lock_up();
      apply(4'b0100, 1'b0);
    end
    lock_up();
    for (int k = 0; k < 7; k++) begin
      apply(4'b0010, 1'b0);
      apply(4'b0100, 1'b0);
      apply(4'b1000, 1'b0);
      apply(4'b0001, 1'b0);
    end
    check_val("pre_reset_err", int'(bus.err_count), 5);
    check_val("pre_reset_rev", int'(bus.rev_count), 7);
    check_val("pre_reset_locked", int'(bus.locked), 1);
    apply(4'b0010, 1'b1);
    check_val("post_reset_word", int'(dut_word()), 0);

    // err_count saturation, then revolution counter wrap.
    for (int k = 0; k < 300; k++) begin
      lock_up();
      apply(4'b0100, 1'b0);
    end
    check_val("err_saturated", int'(bus.err_count), 255);
    lock_up();
    for (int k = 0; k < 260; k++) begin
      apply(4'b0010, 1'b0);
      apply(4'b0100, 1'b0);
      apply(4'b1000, 1'b0);
      apply(4'b0001, 1'b0);
    end
    check_val("rev_wrapped", int'(bus.rev_count), 4);
    check_val("err_still_sat", int'(bus.err_count), 255);

    // Random samples biased toward correct advances and zero runs.
    apply(4'b0000, 1'b1);
    for (int k = 0; k < 3000; k++) begin
      pick = int'($urandom_range(0, 99));
      if (pick < 55) begin
        s = (m_prev_pos >= 0) ? 4'(4'b0001 << ((m_prev_pos + 1) % 4)) : 4'b0001;
      end else if (pick < 75) begin
        s = 4'b0000;
      end else begin
        s = 4'($urandom_range(0, 15));
      end
      apply(s, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
